pmem_arbiter: RTL and testbench
===============================

Name: pmem_arbiter

Overview:
- Shares the single burst physical-memory port (pmem_*) between the instruction cache (line reads only) and the data cache (line reads and writebacks).
- Arbitrates whole-line transactions and converts each 256-bit line into a 4-beat x 64-bit burst.
- Sits between the two caches and the top-level pmem pins.
- Owns sequencing of every memory transaction in the core.

Parameters:
- ADDR_W, 32, address width.
- LINE_W, 256, cache line width.
- BEAT_W, 64, burst beat width. BEATS = LINE_W/BEAT_W = 4 is a derived localparam.

Ports:
- clk  in  1  clock, rising edge.
- rst  in  1  reset, asynchronous, active-low.
- i_read  in  1  icache line read request, held until i_resp.
- i_addr  in  ADDR_W  icache line address.
- i_rdata  out  LINE_W  icache line data, valid while i_resp.
- i_resp  out  1  one-cycle icache completion pulse.
- d_read  in  1  dcache line read request.
- d_write  in  1  dcache line writeback request.
- d_addr  in  ADDR_W  dcache line address.
- d_wdata  in  LINE_W  dcache writeback line.
- d_rdata  out  LINE_W  dcache line data, valid while d_resp.
- d_resp  out  1  one-cycle dcache completion pulse.
- pmem_read  out  1  burst read.
- pmem_write  out  1  burst write.
- pmem_address  out  ADDR_W  line-aligned burst address.
- pmem_wdata  out  BEAT_W  current write beat.
- pmem_rdata  in  BEAT_W  current read beat.
- pmem_resp  in  1  beat handshake; one beat moves per cycle it is high.

Behaviour:
- Reset (rst low, async): state IDLE, beat counter 0. All outputs 0, including rdata buffers. Last-grant flag set to ICACHE.
- States: IDLE, I_RD, D_RD, D_WR, DONE. All outputs are registered or decoded from state only; there is no combinational path from requests to pmem_*.
- IDLE:
  - Priority when requests compete: d_write/d_read over i_read (fixed), unless ARB_RR_EN.
  - Grant: latch the owner, latch the address with bits [4:0] forced to 0, and latch d_wdata for a write.
  - Go to D_WR, D_RD or I_RD. pmem_read/pmem_write assert the cycle after the request is sampled.
- I_RD/D_RD:
  - pmem_read=1.
  - On each pmem_resp, write pmem_rdata into beat slot [cnt*64 +: 64] and increment cnt.
  - On the 4th beat (cnt==3 and pmem_resp), go to DONE and drop pmem_read that same edge.
- D_WR:
  - pmem_write=1, pmem_wdata = latched line slice cnt.
  - Advance on pmem_resp; after the 4th beat, go to DONE.
- DONE:
  - Exactly one cycle: owner's resp=1 and its rdata holds the assembled line.
  - Then go to IDLE. The requester drops its request in this cycle, so no stale regrant occurs.
- Latency with zero memory wait: request sampled at T0, pmem_* asserted T1, beats T1..T4, resp at T5.
- Wait states (pmem_resp low) stall cnt; there is no timeout.
- pmem_resp high in IDLE or DONE: ignored.
- d_read and d_write both high: illegal. Write wins; simulation assertion fires.
- A request arriving while busy is held pending and is not dropped.
- Address or wdata changes mid-transaction are ignored because the values are latched.
- cnt is 2 bits and wraps 3→0 on the final beat.
- Reset mid-burst aborts immediately with outputs to 0. The memory model must be reset with the core.

Optional Feature:
- ARB_RR_EN defined: when both caches request in the same IDLE cycle, grant the cache not granted last. The last-grant flag updates on every grant.
- ARB_RR_EN undefined: dcache always wins. The last-grant flag is not synthesized.

Decomposition:
- Shared package pmem_arb_pkg: state enum (IDLE, I_RD, D_RD, D_WR, DONE), owner enum (OWN_I, OWN_D), localparams LINE_W, BEAT_W, BEATS, OFFSET_BITS=5.
- One sub-module, line_burst_adaptor: owns cnt, the line buffer, beat slicing/assembly and the last-beat flag.
- pmem_arbiter keeps the grant FSM and the resp/rdata routing.

Test Plan:
- i_read, i_addr=0x0000_0064, memory returns beats 0x11..,0x22..,0x33..,0x44.. with no wait → pmem_address=0x60, i_resp one cycle at T5, i_rdata={0x44..,0x33..,0x22..,0x11..}, d_resp stays 0.
- d_write, d_addr=0x8000_0020, d_wdata=beats A/B/C/D, 2 wait cycles before each beat → pmem_wdata A,B,C,D in order, each held until its resp; d_resp after the 4th beat.
- i_read and d_read same cycle, default build → dcache served first, icache immediately after its DONE. With ARB_RR_EN and last grant=D → icache first.
- i_read arrives at T2 during a dcache burst → stays pending, granted the cycle after dcache DONE, correct line returned.
- rst pulled low at beat 2 of an icache read → pmem_read=0 and i_resp=0 asynchronously. After release, a new d_read completes normally.
- Requester holds i_read through DONE and drops it after → exactly one pmem burst, no duplicate grant.

Source files
------------

// File: rtl/pmem_arb_pkg.sv
// Shared types and sizing constants for the physical-memory arbiter.
// Optional feature macro used by the arbiter: ARB_RR_EN (round-robin on contention).
package pmem_arb_pkg;

  localparam int unsigned LINE_W      = 256;
  localparam int unsigned BEAT_W      = 64;
  localparam int unsigned BEATS       = LINE_W / BEAT_W;
  localparam int unsigned OFFSET_BITS = 5;

  // Grant FSM states.
  typedef enum logic [2:0] {
    IDLE,
    I_RD,
    D_RD,
    D_WR,
    DONE
  } state_e;

  // Which cache owns the current transaction.
  typedef enum logic {
    OWN_I,
    OWN_D
  } owner_e;

endpackage

// File: rtl/line_burst_adaptor.sv
// Converts between one cache line and a burst of BEATS beats.
// Owns the beat counter, the line buffer (write source / read assembly)
// and the last-beat flag used by the arbiter FSM.
module line_burst_adaptor #(
  parameter int unsigned LINE_W = pmem_arb_pkg::LINE_W,
  parameter int unsigned BEAT_W = pmem_arb_pkg::BEAT_W
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              load_i,        // grant strobe: restart the burst
  input  logic              load_line_i,   // also capture line_i (writeback)
  input  logic [LINE_W-1:0] line_i,
  input  logic              rd_active_i,   // a read burst is in progress
  input  logic              wr_active_i,   // a write burst is in progress
  input  logic              beat_resp_i,
  input  logic [BEAT_W-1:0] beat_rdata_i,
  output logic [BEAT_W-1:0] beat_wdata_o,
  output logic [LINE_W-1:0] line_o,
  output logic              last_beat_o
);

  localparam int unsigned BEATS = LINE_W / BEAT_W;
  localparam int unsigned CNT_W = (BEATS > 1) ? $clog2(BEATS) : 1;
  localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(BEATS - 1);

  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic [LINE_W-1:0] line_q, line_d;
  logic              beat_fire;

  // A beat moves only while a burst is active; stray handshakes are ignored.
  assign beat_fire   = (rd_active_i | wr_active_i) & beat_resp_i;
  assign last_beat_o = beat_fire && (cnt_q == LAST_CNT);

  // Next counter/buffer value: reload on grant, advance and assemble on each beat.
  always_comb begin
    // NOTE: every variable gets a default first, so no path through the block
    // leaves it unassigned and no latch is inferred.
    cnt_d  = cnt_q;
    line_d = line_q;
    if (load_i) begin
      cnt_d = '0;
      if (load_line_i) begin
        line_d = line_i;
      end
    end else if (beat_fire) begin
      cnt_d = cnt_q + CNT_W'(1);   // wraps to 0 on the final beat
      if (rd_active_i) begin
        line_d[int'(cnt_q)*BEAT_W +: BEAT_W] = beat_rdata_i;
      end
    end
  end

  // Counter and line buffer registers.
  always_ff @(posedge clk or negedge rst_n) begin
    // NOTE: sequential state uses non-blocking assignments so every register
    // samples pre-edge values regardless of statement order.
    if (!rst_n) begin
      cnt_q  <= '0;
      // NOTE: the line buffer is reset too, because its contents are visible
      // on the rdata outputs and must read as zero out of reset.
      line_q <= '0;
    end else begin
      cnt_q  <= cnt_d;
      line_q <= line_d;
    end
  end

  // Current write beat is a slice of the latched line; zero when not writing.
  assign beat_wdata_o = wr_active_i ? line_q[int'(cnt_q)*BEAT_W +: BEAT_W] : '0;
  assign line_o       = line_q;

endmodule

// File: rtl/pmem_arbiter.sv
// Arbitrates icache line reads and dcache line reads/writebacks onto one
// burst physical-memory port. Each line moves as a burst of LINE_W/BEAT_W beats.
// Optional macro ARB_RR_EN: on simultaneous requests grant the cache not
// granted last; otherwise the dcache always wins.
module pmem_arbiter #(
  parameter int unsigned ADDR_W = 32,
  parameter int unsigned LINE_W = pmem_arb_pkg::LINE_W,
  parameter int unsigned BEAT_W = pmem_arb_pkg::BEAT_W
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              i_read,
  input  logic [ADDR_W-1:0] i_addr,
  output logic [LINE_W-1:0] i_rdata,
  output logic              i_resp,
  input  logic              d_read,
  input  logic              d_write,
  input  logic [ADDR_W-1:0] d_addr,
  input  logic [LINE_W-1:0] d_wdata,
  output logic [LINE_W-1:0] d_rdata,
  output logic              d_resp,
  output logic              pmem_read,
  output logic              pmem_write,
  output logic [ADDR_W-1:0] pmem_address,
  output logic [BEAT_W-1:0] pmem_wdata,
  input  logic [BEAT_W-1:0] pmem_rdata,
  input  logic              pmem_resp
);

  import pmem_arb_pkg::*;

  localparam logic [ADDR_W-1:0] OFFSET_MASK = ADDR_W'((1 << OFFSET_BITS) - 1);

  state_e            state_q, state_d;
  owner_e            owner_q, owner_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic              want_i, want_d, pick_d, grant;
  logic              rd_active, wr_active, last_beat;
  logic [LINE_W-1:0] line;

  assign want_i = i_read;
  assign want_d = d_read | d_write;

`ifdef ARB_RR_EN
  owner_e last_grant_q;

  // On contention the dcache wins only if the icache was granted last.
  assign pick_d = want_d & (~want_i | (last_grant_q == OWN_I));

  // Remember who was granted most recently.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      last_grant_q <= OWN_I;
    end else if (grant) begin
      last_grant_q <= owner_d;
    end
  end
`else
  assign pick_d = want_d;
`endif

  assign grant   = (state_q == IDLE) && (want_i || want_d);
  assign owner_d = pick_d ? OWN_D : OWN_I;
  // Line-align the granted address; all bits feed the mask so none go unused.
  assign addr_d  = (pick_d ? d_addr : i_addr) & ~OFFSET_MASK;

  // State register.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // Next-state logic: grant in IDLE, finish a burst on its last beat, DONE lasts one cycle.
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      IDLE: begin
        if (pick_d) begin
          // A simultaneous d_read/d_write is illegal; the writeback wins.
          state_d = d_write ? D_WR : D_RD;
        end else if (want_i) begin
          state_d = I_RD;
        end
      end
      I_RD, D_RD, D_WR: begin
        if (last_beat) begin
          state_d = DONE;
        end
      end
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // Owner and address are captured at grant so later request changes are ignored.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      owner_q <= OWN_I;
      addr_q  <= '0;
    end else if (grant) begin
      owner_q <= owner_d;
      addr_q  <= addr_d;
    end
  end

  assign rd_active = (state_q == I_RD) || (state_q == D_RD);
  assign wr_active = (state_q == D_WR);

  line_burst_adaptor #(
    .LINE_W (LINE_W),
    .BEAT_W (BEAT_W)
  ) u_adaptor (
    .clk          (clk),
    .rst_n        (rst),
    .load_i       (grant),
    .load_line_i  (pick_d & d_write),
    .line_i       (d_wdata),
    .rd_active_i  (rd_active),
    .wr_active_i  (wr_active),
    .beat_resp_i  (pmem_resp),
    .beat_rdata_i (pmem_rdata),
    .beat_wdata_o (pmem_wdata),
    .line_o       (line),
    .last_beat_o  (last_beat)
  );

  // Outputs decoded from registered state only; rdata is shown only during resp.
  always_comb begin
    pmem_read  = rd_active;
    pmem_write = wr_active;
    i_resp     = (state_q == DONE) && (owner_q == OWN_I);
    d_resp     = (state_q == DONE) && (owner_q == OWN_D);
    i_rdata    = '0;
    d_rdata    = '0;
    if (i_resp) begin
      i_rdata = line;
    end
    if (d_resp) begin
      d_rdata = line;
    end
  end

  assign pmem_address = addr_q;

  // Both dcache strobes together indicate a cache controller bug.
  a_no_dual_dreq: assert property (@(posedge clk) disable iff (!rst) !(d_read && d_write))
    else $error("pmem_arbiter: d_read and d_write asserted together");

endmodule

// File: tb/tb_pmem_arbiter.sv
// Directed bench for pmem_arbiter with a beat-level memory responder.
module tb_pmem_arbiter;

  logic         clk = 1'b0;
  logic         rst = 1'b0;
  logic         i_read = 1'b0;
  logic [31:0]  i_addr = '0;
  logic [255:0] i_rdata;
  logic         i_resp;
  logic         d_read = 1'b0;
  logic         d_write = 1'b0;
  logic [31:0]  d_addr = '0;
  logic [255:0] d_wdata = '0;
  logic [255:0] d_rdata;
  logic         d_resp;
  logic         pmem_read;
  logic         pmem_write;
  logic [31:0]  pmem_address;
  logic [63:0]  pmem_wdata;
  logic [63:0]  pmem_rdata = '0;
  logic         pmem_resp = 1'b0;

  int checks   = 0;
  int failures = 0;

  pmem_arbiter dut (
    .clk          (clk),
    .rst          (rst),
    .i_read       (i_read),
    .i_addr       (i_addr),
    .i_rdata      (i_rdata),
    .i_resp       (i_resp),
    .d_read       (d_read),
    .d_write      (d_write),
    .d_addr       (d_addr),
    .d_wdata      (d_wdata),
    .d_rdata      (d_rdata),
    .d_resp       (d_resp),
    .pmem_read    (pmem_read),
    .pmem_write   (pmem_write),
    .pmem_address (pmem_address),
    .pmem_wdata   (pmem_wdata),
    .pmem_rdata   (pmem_rdata),
    .pmem_resp    (pmem_resp)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [255:0] got, input logic [255:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  // Memory contents: beat k of line 0x60 is byte 0x11*(k+1) repeated;
  // other lines are distinguished by their address in the upper word.
  function automatic logic [63:0] mem_word(input logic [31:0] a, input int k);
    logic [7:0] b;
    b = 8'((k + 1) * 17);
    return {8{b}} ^ {a - 32'h60, 32'h0};
  endfunction

  function automatic logic [255:0] exp_line(input logic [31:0] a);
    logic [255:0] l;
    logic [31:0]  al;
    al = a & ~32'h1f;
    for (int k = 0; k < 4; k++) l[k*64 +: 64] = mem_word(al, k);
    return l;
  endfunction

  int cyc = 0;
  always @(posedge clk) cyc++;

  // Memory responder: wait_cfg idle cycles before each beat.
  int          wait_cfg = 0;
  int          mem_beat = 0;
  int          wcnt = 0;
  logic        prev_act = 1'b0;
  int          burst_cnt = 0;
  logic [31:0] burst_addr[$];
  logic [63:0] wr_log[$];
  int          hold_err = 0;
  logic [63:0] first_wdata = '0;
  int          i_resp_cnt = 0;
  int          d_resp_cnt = 0;

  always @(negedge clk or negedge rst) begin
    if (!rst) begin
      pmem_resp = 1'b0;
      pmem_rdata = '0;
      mem_beat = 0;
      wcnt = 0;
      prev_act = 1'b0;
    end else begin
      if (i_resp) i_resp_cnt++;
      if (d_resp) d_resp_cnt++;
      if (pmem_read || pmem_write) begin
        if (!prev_act) begin
          burst_cnt++;
          burst_addr.push_back(pmem_address);
        end
        prev_act = 1'b1;
        if (pmem_write) begin
          if (wcnt == 0) first_wdata = pmem_wdata;
          else if (pmem_wdata !== first_wdata) hold_err++;
        end
        if (wcnt == wait_cfg) begin
          pmem_resp = 1'b1;
          pmem_rdata = pmem_read ? mem_word(pmem_address, mem_beat) : '0;
          if (pmem_write) wr_log.push_back(pmem_wdata);
          mem_beat++;
          wcnt = 0;
        end else begin
          pmem_resp = 1'b0;
          pmem_rdata = '0;
          wcnt++;
        end
      end else begin
        pmem_resp = 1'b0;
        pmem_rdata = '0;
        mem_beat = 0;
        wcnt = 0;
        prev_act = 1'b0;
      end
    end
  end

  // icache requester: hold i_read until i_resp (optionally one cycle longer).
  task automatic req_i(input logic [31:0] a, input bit hold_extra,
                       output logic [255:0] line, output int lat, output int done_cyc);
    bit found = 1'b0;
    i_addr = a; i_read = 1'b1; lat = 0; line = '0; done_cyc = -1;
    while (!found && lat < 200) begin
      @(posedge clk); #1; lat++;
      if (i_resp) begin found = 1'b1; line = i_rdata; done_cyc = cyc; end
    end
    check("i_resp_seen", 256'(found), 256'(1));
    if (found && hold_extra) begin
      @(posedge clk); #1;
      check("i_resp_single", 256'(i_resp), 256'(0));
    end
    i_read = 1'b0;
  endtask

  // dcache requester: read or writeback, held until d_resp.
  task automatic req_d(input logic [31:0] a, input bit wr, input logic [255:0] wline,
                       output logic [255:0] line, output int lat, output int done_cyc);
    bit found = 1'b0;
    d_addr = a; d_wdata = wline; d_write = wr; d_read = ~wr;
    lat = 0; line = '0; done_cyc = -1;
    while (!found && lat < 200) begin
      @(posedge clk); #1; lat++;
      if (d_resp) begin found = 1'b1; line = d_rdata; done_cyc = cyc; end
    end
    check("d_resp_seen", 256'(found), 256'(1));
    d_read = 1'b0; d_write = 1'b0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog expired");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [255:0] li, ld, wline;
    int lat_i, lat_d, done_i, done_d, b0, ic0, dc0, g;
    bit first_is_i;

    // Reset state.
    #1;
    check("rst_pmem_read",  256'(pmem_read), 256'(0));
    check("rst_pmem_write", 256'(pmem_write), 256'(0));
    check("rst_pmem_addr",  256'(pmem_address), 256'(0));
    check("rst_pmem_wdata", 256'(pmem_wdata), 256'(0));
    check("rst_resps",      256'({i_resp, d_resp}), 256'(0));
    check("rst_i_rdata",    i_rdata, 256'(0));
    check("rst_d_rdata",    d_rdata, 256'(0));
    repeat (2) @(negedge clk);
    rst = 1'b1;

    // 1) icache read, zero wait, request held one cycle past DONE.
    @(posedge clk); #1;
    ic0 = i_resp_cnt; dc0 = d_resp_cnt; b0 = burst_cnt;
    req_i(32'h0000_0064, 1'b1, li, lat_i, done_i);
    check("t1_line", li, 256'h4444444444444444_3333333333333333_2222222222222222_1111111111111111);
    check("t1_latency", 256'(lat_i), 256'(5));
    check("t1_addr", 256'(burst_addr[b0]), 256'(32'h0000_0060));
    repeat (6) @(posedge clk); #1;
    check("t1_i_resp_pulses", 256'(i_resp_cnt - ic0), 256'(1));
    check("t1_no_d_resp", 256'(d_resp_cnt - dc0), 256'(0));
    check("t6_single_burst", 256'(burst_cnt - b0), 256'(1));

    // 2) dcache writeback with 2 wait cycles per beat; inputs change mid-burst.
    wait_cfg = 2;
    wr_log.delete();
    hold_err = 0;
    b0 = burst_cnt;
    wline = {64'hDDDD_DDDD_DDDD_DDDD, 64'hCCCC_CCCC_CCCC_CCCC,
             64'hBBBB_BBBB_BBBB_BBBB, 64'hAAAA_AAAA_AAAA_AAAA};
    @(posedge clk); #1;
    fork
      req_d(32'h8000_0020, 1'b1, wline, ld, lat_d, done_d);
      begin
        repeat (3) @(posedge clk); #2;
        d_addr = 32'hDEAD_BEEF;
        d_wdata = {4{64'h0BAD_0BAD_0BAD_0BAD}};
      end
    join
    check("t2_beats", 256'(wr_log.size()), 256'(4));
    if (wr_log.size() == 4) begin
      check("t2_beat0", 256'(wr_log[0]), 256'(64'hAAAA_AAAA_AAAA_AAAA));
      check("t2_beat1", 256'(wr_log[1]), 256'(64'hBBBB_BBBB_BBBB_BBBB));
      check("t2_beat2", 256'(wr_log[2]), 256'(64'hCCCC_CCCC_CCCC_CCCC));
      check("t2_beat3", 256'(wr_log[3]), 256'(64'hDDDD_DDDD_DDDD_DDDD));
    end
    check("t2_wdata_held", 256'(hold_err), 256'(0));
    check("t2_latency", 256'(lat_d), 256'(13));
    check("t2_addr", 256'(burst_addr[b0]), 256'(32'h8000_0020));
    wait_cfg = 0;

    // 3) Simultaneous requests; last grant was the dcache.
`ifdef ARB_RR_EN
    first_is_i = 1'b1;
`else
    first_is_i = 1'b0;
`endif
    @(posedge clk); #1;
    fork
      req_d(32'h0000_1000, 1'b0, '0, ld, lat_d, done_d);
      req_i(32'h0000_2040, 1'b0, li, lat_i, done_i);
    join
    check("t3_order", 256'(done_i < done_d), 256'(first_is_i));
    check("t3_gap", 256'(first_is_i ? done_d - done_i : done_i - done_d), 256'(6));
    check("t3_d_line", ld, exp_line(32'h0000_1000));
    check("t3_i_line", li, exp_line(32'h0000_2040));

    // 4) icache request arrives two cycles into a dcache burst.
    @(posedge clk); #1;
    fork
      req_d(32'h0000_3000, 1'b0, '0, ld, lat_d, done_d);
      begin
        repeat (2) @(posedge clk); #1;
        req_i(32'h0000_40A4, 1'b0, li, lat_i, done_i);
      end
    join
    check("t4_pending_gap", 256'(done_i - done_d), 256'(6));
    check("t4_d_line", ld, exp_line(32'h0000_3000));
    check("t4_i_line", li, exp_line(32'h0000_40A0));

    // 5) Reset at beat 2 of an icache read, then a normal dcache read.
    @(posedge clk); #1;
    i_addr = 32'h0000_0140; i_read = 1'b1;
    g = 0;
    while (mem_beat != 2 && g < 50) begin
      @(negedge clk); #1; g++;
    end
    check("t5_reached_beat2", 256'(mem_beat), 256'(2));
    #1;
    rst = 1'b0;
    #1;
    check("t5_rst_pmem_read", 256'(pmem_read), 256'(0));
    check("t5_rst_i_resp",    256'(i_resp), 256'(0));
    check("t5_rst_addr",      256'(pmem_address), 256'(0));
    check("t5_rst_i_rdata",   i_rdata, 256'(0));
    i_read = 1'b0;
    repeat (2) @(negedge clk);
    rst = 1'b1;
    @(posedge clk); #1;
    req_d(32'h0000_0200, 1'b0, '0, ld, lat_d, done_d);
    check("t5_d_line", ld, exp_line(32'h0000_0200));
    check("t5_d_latency", 256'(lat_d), 256'(5));

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
